// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//   Decode stage of the 9-bit CPU. Takes raw instruction words from fetch
//   over a valid/ready handshake, splits each into opcode [8:4] and operand
//   [3:0], classifies the operand, and folds litl/lith nibbles into an 8-bit
//   literal. The decoded record goes to execute through a registered output
//   stage with a one-entry skid buffer, so in_ready never depends
//   combinationally on out_ready.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   in_valid       fetch presents a word
//   in_instr       raw instruction [INSTR_W-1:0]
//   in_ready       decode can accept (skid register empty)
//   flush          branch taken: drop everything in flight
//   out_valid      decoded record valid
//   out_ready      execute accepts the record
//   out_op         opcode (0..31)
//   out_reg        register operand, 0 unless the opcode names a register
//   out_math       math selector (mthr/mths only)
//   out_func       function selector (func only)
//   out_imm4       raw operand nibble
//   out_lit8       literal accumulator including this record's update
//   out_is_mem     load or stor
//   out_is_branch  jizr, jnzr, bizr or bnzr
//   out_illegal    illegal-instruction trap flag
//
// Configuration
//   DECODE_ILLEGAL_TRAP_EN  when defined, flags zzzz and unguarded ndne/done
//                           funcs as illegal (sticky until reset or flush).
//                           When undefined, out_illegal is tied to 0.
// ---------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int         INSTR_W   = 9,
    parameter logic [7:0] LIT_RESET = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_op,
    output logic [3:0]         out_reg,
    output logic [3:0]         out_math,
    output logic [3:0]         out_func,
    output logic [3:0]         out_imm4,
    output logic [7:0]         out_lit8,
    output logic               out_is_mem,
    output logic               out_is_branch,
    output logic               out_illegal
);

    // The encoding is fixed; any other width is a build error.
    if (INSTR_W != 9) begin : g_bad_instr_w
        $error("instr_decode_stage: INSTR_W must be 9");
    end

    typedef enum logic [4:0] {
        OP_LITL, OP_LITH, OP_MOVC, OP_MOVD, OP_MOVM, OP_MOVN, OP_MOVX, OP_MOVY,
        OP_MOVA, OP_MOVB, OP_MOVI, OP_MOVJ, OP_MOVK, OP_MOVL, OP_MOVZ, OP_MOVP,
        OP_LOAD, OP_STOR, OP_INCR, OP_DECR, OP_JIZR, OP_JNZR, OP_BIZR, OP_BNZR,
        OP_ZZZZ, OP_SETH, OP_MTHR, OP_MTHS, OP_LSLC, OP_LSRC, OP_FLIP, OP_FUNC
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [3:0] rsel;
        logic [3:0] math;
        logic [3:0] func;
        logic [3:0] imm4;
        logic [7:0] lit8;
        logic       is_mem;
        logic       is_branch;
        logic       illegal;
    } rec_t;

    opcode_e    op_in;
    logic [3:0] operand;
    logic [7:0] lit_acc;
    logic [7:0] lit_next;
    logic       illegal_now;
    rec_t       dec;
    rec_t       out_rec;
    rec_t       skid_rec;
    logic       skid_full;
    logic       accept;
    logic       out_xfer;

    assign op_in    = opcode_e'(in_instr[8:4]);
    assign operand  = in_instr[3:0];
    assign in_ready = !skid_full;
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // ---- combinational decode of the word on in_instr ----
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        lit_next = lit_acc;
        if (op_in == OP_LITL) lit_next[3:0] = operand;
        else if (op_in == OP_LITH) lit_next[7:4] = operand;

        dec         = '0;
        dec.op      = op_in;
        dec.imm4    = operand;
        dec.lit8    = lit_next;
        dec.illegal = illegal_now;
        case (op_in)
            OP_MOVC, OP_MOVD, OP_MOVM, OP_MOVN, OP_MOVX, OP_MOVY, OP_MOVA, OP_MOVB,
            OP_MOVI, OP_MOVJ, OP_MOVK, OP_MOVL, OP_MOVZ, OP_MOVP,
            OP_INCR, OP_DECR, OP_SETH, OP_LSLC, OP_LSRC, OP_FLIP:
                dec.rsel = operand;
            OP_LOAD, OP_STOR: begin
                dec.rsel   = operand;
                dec.is_mem = 1'b1;
            end
            OP_JIZR, OP_JNZR, OP_BIZR, OP_BNZR: dec.is_branch = 1'b1;
            OP_MTHR, OP_MTHS:                   dec.math      = operand;
            OP_FUNC:                            dec.func      = operand;
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // ndne/done (14/15) are only legal right after a string setup func.
    localparam logic [3:0] FUNC_STRL = 4'd12;
    localparam logic [3:0] FUNC_STRH = 4'd13;

    logic ill_sticky;
    logic prev_func_str;
    logic ill_hit;

    assign ill_hit = (op_in == OP_ZZZZ) ||
                     ((op_in == OP_FUNC) && (operand >= 4'd14) && !prev_func_str);
    assign illegal_now = ill_sticky || ill_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            ill_sticky    <= 1'b0;
            prev_func_str <= 1'b0;
        end else if (flush) begin
            // The discarded word must not update func history either.
            ill_sticky <= 1'b0;
        end else if (accept) begin
            ill_sticky <= illegal_now;
            if (op_in == OP_FUNC)
                prev_func_str <= (operand == FUNC_STRL) || (operand == FUNC_STRH);
        end
    end
`else
    assign illegal_now = 1'b0;
`endif

    // ---- output register, occupancy and literal accumulator ----
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, whatever the order.
        if (reset) begin
            out_valid    <= 1'b0;
            skid_full    <= 1'b0;
            out_rec      <= '0;
            out_rec.lit8 <= LIT_RESET;
            lit_acc      <= LIT_RESET;
        end else if (flush) begin
            // Drop in-flight records; a word accepted now is discarded and
            // its literal update is not applied.
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            if (accept) lit_acc <= lit_next;

            if (skid_full) begin
                if (out_xfer) begin
                    out_rec   <= skid_rec;
                    skid_full <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid || out_ready) begin
                    out_rec   <= dec;
                    out_valid <= 1'b1;
                end else begin
                    skid_full <= 1'b1;
                end
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the skid payload has no reset; skid_full alone says whether it
    // holds anything, so its contents are never observed while stale.
    always_ff @(posedge clk) begin
        if (accept && out_valid && !out_ready && !skid_full)
            skid_rec <= dec;
    end

    assign out_op        = out_rec.op;
    assign out_reg       = out_rec.rsel;
    assign out_math      = out_rec.math;
    assign out_func      = out_rec.func;
    assign out_imm4      = out_rec.imm4;
    assign out_lit8      = out_rec.lit8;
    assign out_is_mem    = out_rec.is_mem;
    assign out_is_branch = out_rec.is_branch;
    assign out_illegal   = out_rec.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//   Directed bench for instr_decode_stage: decode fields, literal assembly,
//   skid-buffer back-pressure and ordering, flush, reset mid-stall and the
//   illegal flag (expectation follows DECODE_ILLEGAL_TRAP_EN).
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_op;
    logic [3:0] out_reg;
    logic [3:0] out_math;
    logic [3:0] out_func;
    logic [3:0] out_imm4;
    logic [7:0] out_lit8;
    logic       out_is_mem;
    logic       out_is_branch;
    logic       out_illegal;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.INSTR_W(9), .LIT_RESET(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_reg       (out_reg),
        .out_math      (out_math),
        .out_func      (out_func),
        .out_imm4      (out_imm4),
        .out_lit8      (out_lit8),
        .out_is_mem    (out_is_mem),
        .out_is_branch (out_is_branch),
        .out_illegal   (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 9'h000;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid",   out_valid,   0);
        check("rst_ready",   in_ready,    1);
        check("rst_lit8",    out_lit8,    8'h00);
        check("rst_op",      out_op,      0);
        check("rst_illegal", out_illegal, 0);
        reset = 1'b0;

        // Literal assembly: litl 5 then lith A.
        in_valid = 1'b1; in_instr = 9'h005;
        tick();
        check("litl_valid", out_valid, 1);
        check("litl_op",    out_op,    0);
        check("litl_imm4",  out_imm4,  4'h5);
        check("litl_lit8",  out_lit8,  8'h05);
        in_instr = 9'h01A;
        tick();
        check("lith_op",   out_op,   1);
        check("lith_lit8", out_lit8, 8'hA5);

        // mthr add
        in_instr = 9'h1A8;
        tick();
        check("mthr_op",   out_op,     26);
        check("mthr_math", out_math,   8);
        check("mthr_reg",  out_reg,    0);
        check("mthr_mem",  out_is_mem, 0);
        check("mthr_lit8", out_lit8,   8'hA5);

        // load x
        in_instr = 9'h106;
        tick();
        check("load_op",   out_op,     16);
        check("load_reg",  out_reg,    6);
        check("load_mem",  out_is_mem, 1);
        check("load_math", out_math,   0);

        // jnzr: branch, no register
        in_instr = 9'h154;
        tick();
        check("jnzr_op",  out_op,        21);
        check("jnzr_br",  out_is_branch, 1);
        check("jnzr_reg", out_reg,       0);

        // func 3
        in_instr = 9'h1F3;
        tick();
        check("func_op",   out_op,        31);
        check("func_func", out_func,      3);
        check("func_reg",  out_reg,       0);
        check("func_br",   out_is_branch, 0);

        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // Back-pressure: two words fit, the third waits.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 9'h106;
        tick();
        check("stall1_valid", out_valid, 1);
        check("stall1_ready", in_ready,  1);
        in_instr = 9'h107;
        tick();
        check("stall2_ready", in_ready, 0);
        check("stall2_reg",   out_reg,  6);
        in_instr = 9'h108;
        tick();
        check("stall3_ready", in_ready, 0);
        check("stall3_reg",   out_reg,  6);
        out_ready = 1'b1;
        tick();
        check("order2_reg",   out_reg,   7);
        check("order2_ready", in_ready,  1);
        tick();
        check("order3_reg",   out_reg,   8);
        check("order3_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("order_drain", out_valid, 0);

        // Flush with two records buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 9'h106;
        tick();
        in_instr = 9'h107;
        tick();
        check("pre_flush_ready", in_ready, 0);
        flush = 1'b1; in_instr = 9'h005;
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready,  1);
        check("flush_lit8",  out_lit8,  8'hA5);
        // Word accepted during flush: litl 3 must not reach the accumulator.
        in_instr = 9'h003;
        tick();
        check("flush2_valid", out_valid, 0);
        flush = 1'b0; out_ready = 1'b1; in_instr = 9'h106;
        tick();
        check("post_flush_valid", out_valid, 1);
        check("post_flush_lit8",  out_lit8,  8'hA5);
        in_valid = 1'b0;
        tick();

        // Reset mid-stall with two records held.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 9'h106;
        tick();
        in_instr = 9'h107;
        tick();
        check("pre_rst_ready", in_ready, 0);
        reset = 1'b1; in_valid = 1'b0;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready,  1);
        check("mrst_lit8",  out_lit8,  8'h00);
        check("mrst_reg",   out_reg,   0);
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 9'h00F;
        tick();
        check("rlit_lit8", out_lit8, 8'h0F);

        // Illegal trap: zzzz, then sticky, then cleared by flush.
        in_instr = 9'h180;
        tick();
        check("zzzz_op",  out_op,      24);
        check("zzzz_ill", out_illegal, ILL_EXP);
        in_instr = 9'h106;
        tick();
        check("sticky_ill", out_illegal, ILL_EXP);
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0; in_valid = 1'b1; in_instr = 9'h106;
        tick();
        check("clr_valid", out_valid,   1);
        check("clr_ill",   out_illegal, 0);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
